bpsk_phase_gen: RTL

- Phase-accumulator NCO with BPSK phase modulation.
- Produces the 9-bit phase address that drives cosine_lut (SAMPLES=512, BITS=12), sitting directly upstream of it in the transmit path.
- Accepts one data bit per symbol over a valid/ready handshake and holds it for SAMPLES_PER_SYM samples, adding a half-cycle offset (180°) for bit 1.
- Carrier phase stays continuous across symbols and idle gaps.

---
 rtl/bpsk_pkg.sv | 16 +
 rtl/bpsk_phase_gen_if.sv | 20 ++
 rtl/phase_accumulator.sv | 33 +++
 rtl/bpsk_phase_gen.sv | 113 +++++++++++
 4 files changed

// File: rtl/bpsk_pkg.sv
// rtl/bpsk_pkg.sv - shared types and helpers for the BPSK transmit NCO and the receiver carrier NCO
package bpsk_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  localparam int DEFAULT_ADDR_BITS = 9;

  // 180 degrees expressed in LUT address units
  function automatic int unsigned half_cycle_offset(input int unsigned addr_bits);
    return 32'd1 << (addr_bits - 1);
  endfunction

endpackage

// File: rtl/bpsk_phase_gen_if.sv
// rtl/bpsk_phase_gen_if.sv - symbol bit handshake between the bit source and the BPSK phase generator
interface bpsk_phase_gen_if;

  logic sym_valid;
  logic sym_data;
  logic sym_ready;

  modport master (
    output sym_valid,
    output sym_data,
    input  sym_ready
  );

  modport slave (
    input  sym_valid,
    input  sym_data,
    output sym_ready
  );

endinterface

// File: rtl/phase_accumulator.sv
// rtl/phase_accumulator.sv - enable-gated phase accumulator exposing its top OUT_BITS bits
module phase_accumulator #(
  parameter int ACC_BITS = 32,
  parameter int OUT_BITS = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [ACC_BITS-1:0] ftw,
  output logic [OUT_BITS-1:0] acc_top
);

  logic [ACC_BITS-1:0] acc_q;
  logic [ACC_BITS-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (en) begin
      acc_d = acc_q + ftw;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_top = acc_q[ACC_BITS-1 -: OUT_BITS];

endmodule

// File: rtl/bpsk_phase_gen.sv
// rtl/bpsk_phase_gen.sv - BPSK phase generator: NCO address with per-symbol 180 degree offset
// BPSK_DIFF_ENC_EN selects differential encoding of the symbol bits.
module bpsk_phase_gen
  import bpsk_pkg::*;
#(
  parameter int ACC_BITS        = 32,
  parameter int ADDR_BITS       = DEFAULT_ADDR_BITS,
  parameter int SAMPLES_PER_SYM = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [ACC_BITS-1:0]  ftw,
  bpsk_phase_gen_if.slave      sym,
  output logic [ADDR_BITS-1:0] phase_out,
  output logic                 phase_valid,
  output logic                 sym_strobe,
  output logic                 underrun
);

  localparam int CNT_BITS = (SAMPLES_PER_SYM > 1) ? $clog2(SAMPLES_PER_SYM) : 1;
  localparam logic [CNT_BITS-1:0]  LAST_CNT = CNT_BITS'(SAMPLES_PER_SYM - 1);
  localparam logic [ADDR_BITS-1:0] HALF     = ADDR_BITS'(half_cycle_offset(ADDR_BITS));

  logic [ADDR_BITS-1:0] acc_top;

  state_e               state_q,     state_d;
  logic [CNT_BITS-1:0]  cnt_q,       cnt_d;
  logic                 flip_q,      flip_d;
  logic [ADDR_BITS-1:0] phase_q,     phase_d;
  logic                 pvalid_q,    pvalid_d;
  logic                 strobe_q,    strobe_d;
  logic                 underrun_q,  underrun_d;
  logic                 at_boundary;
  logic                 ready_c;
  logic                 xfer;

  phase_accumulator #(
    .ACC_BITS (ACC_BITS),
    .OUT_BITS (ADDR_BITS)
  ) u_acc (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .ftw     (ftw),
    .acc_top (acc_top)
  );

  always_comb begin
    at_boundary = (state_q == ACTIVE) && (cnt_q == LAST_CNT);
    ready_c     = en && ((state_q == IDLE) || at_boundary);
    xfer        = ready_c && sym.sym_valid;

    state_d    = state_q;
    cnt_d      = cnt_q;
    flip_d     = flip_q;
    phase_d    = phase_q;
    underrun_d = underrun_q;
    pvalid_d   = 1'b0;
    strobe_d   = 1'b0;

    if (en) begin
      if (xfer) begin
        state_d  = ACTIVE;
        cnt_d    = '0;
        strobe_d = 1'b1;
`ifdef BPSK_DIFF_ENC_EN
        flip_d   = flip_q ^ sym.sym_data;
`else
        flip_d   = sym.sym_data;
`endif
      end else if (state_q == ACTIVE) begin
        if (at_boundary) begin
          state_d    = IDLE;
          cnt_d      = '0;
          underrun_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_BITS'(1);
        end
      end
      pvalid_d = (state_d == ACTIVE);
      // the new flip applies to the very first sample of a freshly accepted symbol
      phase_d  = acc_top + (flip_d ? HALF : '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      flip_q     <= 1'b0;
      phase_q    <= '0;
      pvalid_q   <= 1'b0;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      flip_q     <= flip_d;
      phase_q    <= phase_d;
      pvalid_q   <= pvalid_d;
      strobe_q   <= strobe_d;
      underrun_q <= underrun_d;
    end
  end

  assign sym.sym_ready = ready_c;
  assign phase_out     = phase_q;
  assign phase_valid   = pvalid_q;
  assign sym_strobe    = strobe_q;
  assign underrun      = underrun_q;

endmodule
